ring_readout_ctrl: RTL and testbench
====================================

RING_READOUT_CTRL -- requirements
Module: ring_readout_ctrl

Interface
REQ-001 Parameter NODE_NUM, default 16: replica nodes per ring.
REQ-002 Parameter BANK_NUM, default 2: independent rings (banks) selectable for readout; minimum 1.
REQ-003 Parameter WORDS_PER_REP, default 4: 64-bit words per replica ordering (city_div).
REQ-004 Parameter FIFO_DEPTH, default 4: output buffer depth; power of two, minimum 2.
REQ-005 Parameter DATA_W, default 64: word width.
REQ-006 One clock; reset is asynchronous and active-high.
REQ-007 clk  in  1  clock; all state on rising edge.
REQ-008 reset  in  1  asynchronous active-high reset.
REQ-009 start  in  1  single-cycle request to begin a readout; ignored unless idle.
REQ-010 bank_sel  in  max(1,$clog2(BANK_NUM))  bank to read; sampled with start.
REQ-011 mode  in  1  0 = ordering readout, 1 = total-distance readout; sampled with start.
REQ-012 abort  in  1  terminate the current readout at the next cycle.
REQ-013 busy  out  1  high from the cycle after an accepted start until done.
REQ-014 shift  out  BANK_NUM  one-hot ring shift pulse, selected bank only.
REQ-015 in_valid  in  BANK_NUM  per-bank ring output valid.
REQ-016 in_data  in  BANK_NUM x DATA_W  per-bank ring output word.
REQ-017 rd_valid  out  1  output word valid.
REQ-018 rd_data  out  DATA_W  output word.
REQ-019 rd_last  out  1  marks the final word of the readout.
REQ-020 rd_ready  in  1  consumer accepts the word when rd_valid and rd_ready are both high.
REQ-021 done  out  1  single-cycle pulse when a readout completes or is aborted.

Function
REQ-022 Word total N: mode 0 gives NODE_NUM*WORDS_PER_REP; mode 1 gives NODE_NUM.
REQ-023 FSM states: IDLE, SHIFT, DRAIN. IDLE goes to SHIFT on start. SHIFT goes to DRAIN once N shifts are issued. DRAIN goes to IDLE with a done pulse once the FIFO is empty and no capture is outstanding.
REQ-024 The block issues at most one shift pulse per cycle, and only while fifo_count + outstanding < FIFO_DEPTH.
REQ-025 in_data of the selected bank is captured when in_valid is high, exactly 1 cycle after each shift pulse.
REQ-026 If the expected in_valid is absent, the block shall still push in_data, and shall set sticky status bit err_miss, readable as an internal signal until the next start.
REQ-027 Other banks' in_valid and in_data are ignored.
REQ-028 The FIFO is first-word-fall-through. rd_valid equals not-empty. rd_data and rd_last come from the head entry.
REQ-029 rd_last is set on the N-th pushed word only.
REQ-030 A push and a pop in the same cycle when the FIFO is full are legal. The count is unchanged and no word is lost.
REQ-031 The shift counter is $clog2(NODE_NUM*WORDS_PER_REP+1) bits wide and does not wrap. The read pointer wraps modulo FIFO_DEPTH.
REQ-032 The bank toggle register last_bank updates to bank_sel on each accepted start. It exposes the most recently read bank.
REQ-033 Abort in SHIFT or DRAIN: stop shifting, flush the FIFO, drop rd_valid the next cycle, pulse done, return to IDLE. An abort while IDLE has no effect.
REQ-034 start and done in the same cycle: start is ignored.
REQ-035 Throughput: with rd_ready held high, one word per cycle after a 2-cycle start latency (start to first rd_valid).

Reset
REQ-036 Asynchronous reset drives: state IDLE; busy, shift, rd_valid, rd_last, done, and err_miss 0; counters, pointers, and last_bank 0.
REQ-037 Reset mid-readout discards all buffered words. No shift pulse is emitted in the cycle after reset deasserts.

Structure
REQ-038 The readout_mode_t enum (ORDERING, DISTANCE) belongs in replica_pkg. NODE_NUM and WORDS_PER_REP default to replica_pkg node_num and city_div.
REQ-039 One sub-module, readout_fifo, holds the parametrised FWFT FIFO (count, full, empty).

Verification
REQ-040 BANK_NUM=2, mode 0, bank 1, rd_ready=1 -> 64 shift[1] pulses, shift[0] never pulses, 64 words in order, rd_last on word 64, done once.
REQ-041 mode 1, bank 0, rd_ready=0 for 20 cycles -> exactly FIFO_DEPTH=4 shifts, then shifting stalls; on release, 16 words with no loss or duplication.
REQ-042 rd_ready toggling every cycle with FIFO full -> simultaneous push/pop keeps count at 4, data order preserved.
REQ-043 Abort after 10 words -> rd_valid low next cycle, done pulse, busy low; a following start reads a full 64 words.
REQ-044 Reset asserted mid-SHIFT -> all outputs 0 asynchronously, no shift pulse on the first post-reset cycle.
REQ-045 in_valid suppressed on shift 5 -> err_miss set; word count is still N.

Source files
------------

// File: rtl/replica_pkg.sv
// Shared types and defaults for the replica ring readout path.
package replica_pkg;

    localparam int unsigned node_num = 16;
    localparam int unsigned city_div = 4;

    typedef enum logic {
        ORDERING = 1'b0,
        DISTANCE = 1'b1
    } readout_mode_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DRAIN = 2'd2
    } readout_state_t;

    // Number of words a readout produces for the given mode.
    function automatic int unsigned readout_words(input readout_mode_t m,
                                                  input int unsigned nodes,
                                                  input int unsigned wpr);
        return (m == DISTANCE) ? nodes : nodes * wpr;
    endfunction

endpackage

// File: rtl/readout_fifo.sv
// First-word-fall-through FIFO with synchronous flush; head is zero when empty.
module readout_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 65,
    localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             not_empty,
    output logic             full,
    output logic [CW-1:0]    count
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;
    logic             not_empty_q;
    logic             full_q;
    logic             do_push;
    logic             do_pop;

    // A push into a full FIFO is only taken when the head leaves in the same cycle.
    always_comb begin
        do_pop  = pop & not_empty_q;
        do_push = push & (~full_q | do_pop);
        count_d = count_q + CW'(do_push) - CW'(do_pop);
    end

    // Pointers, occupancy and status flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            not_empty_q <= 1'b0;
            full_q      <= 1'b0;
        end else if (flush) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            not_empty_q <= 1'b0;
            full_q      <= 1'b0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q     <= count_d;
            not_empty_q <= (count_d != '0);
            full_q      <= (count_d == CW'(DEPTH));
        end
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr_q] <= push_data;
    end

    assign head_data = not_empty_q ? mem[rd_ptr_q] : '0;
    assign not_empty = not_empty_q;
    assign full      = full_q;
    assign count     = count_q;

endmodule

// File: rtl/ring_readout_ctrl.sv
// Drives one bank's ring shift, captures the returning words and buffers them for the reader.
module ring_readout_ctrl
    import replica_pkg::*;
#(
    parameter int unsigned NODE_NUM      = node_num,
    parameter int unsigned BANK_NUM      = 2,
    parameter int unsigned WORDS_PER_REP = city_div,
    parameter int unsigned FIFO_DEPTH    = 4,
    parameter int unsigned DATA_W        = 64,
    localparam int unsigned BSEL_W       = (BANK_NUM > 1) ? $clog2(BANK_NUM) : 1
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    input  logic [BSEL_W-1:0]              bank_sel,
    input  logic                           mode,
    input  logic                           abort,
    output logic                           busy,
    output logic [BANK_NUM-1:0]            shift,
    input  logic [BANK_NUM-1:0]            in_valid,
    input  logic [BANK_NUM-1:0][DATA_W-1:0] in_data,
    output logic                           rd_valid,
    output logic [DATA_W-1:0]              rd_data,
    output logic                           rd_last,
    input  logic                           rd_ready,
    output logic                           done
);

    localparam int unsigned N_MAX = NODE_NUM * WORDS_PER_REP;
    localparam int unsigned CNT_W = $clog2(N_MAX + 1);
    localparam int unsigned FCW   = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned OCC_W = FCW + 1;
    localparam int unsigned ENT_W = DATA_W + 1;

    readout_state_t      state_q, state_d;
    logic                busy_q;
    logic                done_q;
    logic [BANK_NUM-1:0] shift_q;
    logic                cap_q;
    logic [BSEL_W-1:0]   bank_q;
    logic [BSEL_W-1:0]   last_bank_q;
    logic [CNT_W-1:0]    n_q;
    logic [CNT_W-1:0]    shift_cnt_q;
    logic [CNT_W-1:0]    push_cnt_q;
    logic                err_miss_q;

    logic                accept;
    logic                shift_go;
    logic                flush;
    logic                done_d;
    logic                shift_ok;
    logic [OCC_W-1:0]    occ_next;
    logic [BSEL_W-1:0]   shift_bank;
    logic [CNT_W-1:0]    n_sel;
    logic                push_last;

    logic [ENT_W-1:0]    push_ent;
    logic [ENT_W-1:0]    head_ent;
    logic                fifo_not_empty;
    logic                fifo_full;
    logic [FCW-1:0]      fifo_count;

    // Occupancy after this edge plus the capture already in flight must leave room for a new shift.
    always_comb begin
        occ_next = OCC_W'(fifo_count) + OCC_W'(cap_q) + OCC_W'(|shift_q)
                 - OCC_W'(fifo_not_empty & rd_ready);
        shift_ok = (occ_next < OCC_W'(FIFO_DEPTH));
        n_sel    = CNT_W'(readout_words(readout_mode_t'(mode), NODE_NUM, WORDS_PER_REP));
        push_last = ((push_cnt_q + CNT_W'(1)) == n_q);
        push_ent  = {push_last, in_data[bank_q]};
    end

    // Next-state and control decode; the first shift goes out together with the accepted start.
    always_comb begin
        state_d    = state_q;
        accept     = 1'b0;
        shift_go   = 1'b0;
        flush      = 1'b0;
        done_d     = 1'b0;
        shift_bank = bank_q;
        case (state_q)
            ST_IDLE: begin
                if (start && !done_q) begin
                    accept     = 1'b1;
                    shift_go   = 1'b1;
                    shift_bank = bank_sel;
                    state_d    = (n_sel == CNT_W'(1)) ? ST_DRAIN : ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (abort) begin
                    flush   = 1'b1;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else if (shift_ok) begin
                    shift_go = 1'b1;
                    if ((shift_cnt_q + CNT_W'(1)) == n_q) state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (abort) begin
                    flush   = 1'b1;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else if (!(|shift_q) && !cap_q && !fifo_not_empty) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, registered outputs and readout bookkeeping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            shift_q     <= '0;
            cap_q       <= 1'b0;
            bank_q      <= '0;
            last_bank_q <= '0;
            n_q         <= '0;
            shift_cnt_q <= '0;
            push_cnt_q  <= '0;
            err_miss_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= (state_d != ST_IDLE);
            done_q  <= done_d;
            shift_q <= shift_go ? (BANK_NUM'(1) << shift_bank) : '0;
            cap_q   <= (|shift_q) & ~flush;
            if (accept) begin
                bank_q      <= bank_sel;
                last_bank_q <= bank_sel;
                n_q         <= n_sel;
                shift_cnt_q <= CNT_W'(1);
                push_cnt_q  <= '0;
                err_miss_q  <= 1'b0;
            end else begin
                if (shift_go) shift_cnt_q <= shift_cnt_q + CNT_W'(1);
                if (cap_q && !flush) begin
                    push_cnt_q <= push_cnt_q + CNT_W'(1);
                    if (!in_valid[bank_q]) err_miss_q <= 1'b1;
                end
            end
        end
    end

    readout_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENT_W)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .push      (cap_q & ~flush),
        .push_data (push_ent),
        .pop       (rd_ready),
        .head_data (head_ent),
        .not_empty (fifo_not_empty),
        .full      (fifo_full),
        .count     (fifo_count)
    );

    assign busy     = busy_q;
    assign shift    = shift_q;
    assign done     = done_q;
    assign rd_valid = fifo_not_empty;
    assign rd_data  = head_ent[DATA_W-1:0];
    assign rd_last  = head_ent[DATA_W];

endmodule

// File: tb/tb_ring_readout_ctrl.sv
// Directed bench: ring model per bank, output monitor, hand-derived expectations.
module tb_ring_readout_ctrl;
    import replica_pkg::*;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic             bank_sel;
    logic             mode;
    logic             abort;
    logic             busy;
    logic [1:0]       shift;
    logic [1:0]       in_valid;
    logic [1:0][63:0] in_data;
    logic             rd_valid;
    logic [63:0]      rd_data;
    logic             rd_last;
    logic             rd_ready;
    logic             done;

    ring_readout_ctrl #(
        .NODE_NUM      (16),
        .BANK_NUM      (2),
        .WORDS_PER_REP (4),
        .FIFO_DEPTH    (4),
        .DATA_W        (64)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .bank_sel (bank_sel),
        .mode     (mode),
        .abort    (abort),
        .busy     (busy),
        .shift    (shift),
        .in_valid (in_valid),
        .in_data  (in_data),
        .rd_valid (rd_valid),
        .rd_data  (rd_data),
        .rd_last  (rd_last),
        .rd_ready (rd_ready),
        .done     (done)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] mk_word(input int b, input int i);
        return {16'hCAFE, 16'(b), 32'(i)};
    endfunction

    // Ring model: a shifted bank presents its next word one cycle later; idle banks carry noise.
    int ring_idx [2];
    int miss_idx = -1;
    int cyc = 0;
    always @(posedge clk) begin
        cyc++;
        for (int b = 0; b < 2; b++) begin
            if (shift[b]) begin
                in_data[b]  <= mk_word(b, ring_idx[b]);
                in_valid[b] <= (ring_idx[b] != miss_idx);
                ring_idx[b]++;
            end else begin
                in_data[b]  <= {$urandom, $urandom};
                in_valid[b] <= 1'($urandom_range(0, 1));
            end
        end
    end

    logic toggle = 1'b0;
    always @(posedge clk) begin
        #2;
        if (toggle) rd_ready = ~rd_ready;
    end

    // Monitor: accepted words, shift pulses, done pulses and peak FIFO occupancy.
    logic [63:0] got_d [$];
    bit          got_l [$];
    int          got_c [$];
    int          shift_seen [2];
    int          done_seen;
    int          max_occ;
    always @(negedge clk) begin
        if (!reset) begin
            if (rd_valid && rd_ready) begin
                got_d.push_back(rd_data);
                got_l.push_back(rd_last);
                got_c.push_back(cyc);
            end
            for (int b = 0; b < 2; b++) if (shift[b]) shift_seen[b]++;
            if (done) done_seen++;
            if (int'(dut.u_fifo.count) > max_occ) max_occ = int'(dut.u_fifo.count);
        end
    end

    task automatic clear_log();
        got_d.delete();
        got_l.delete();
        got_c.delete();
        shift_seen = '{0, 0};
        ring_idx   = '{0, 0};
        done_seen  = 0;
        max_occ    = 0;
    endtask

    // Called at posedge+1; returns the cycle in which start was high.
    task automatic issue_start(input logic b, input logic m, output int scyc);
        clear_log();
        bank_sel = b;
        mode     = m;
        start    = 1'b1;
        scyc     = cyc;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int k = 0;
        while (done_seen == 0 && k < 3000) begin
            @(posedge clk); #1;
            k++;
        end
        check_eq({tag, "_done_count"}, 64'(done_seen), 64'd1);
    endtask

    task automatic check_words(input string tag, input int b, input int n);
        check_eq({tag, "_word_count"}, 64'(got_d.size()), 64'(n));
        for (int i = 0; i < got_d.size() && i < n; i++) begin
            check_eq($sformatf("%s_data%0d", tag, i), got_d[i], mk_word(b, i));
            check_eq($sformatf("%s_last%0d", tag, i), 64'(got_l[i]), 64'(i == n - 1));
        end
    endtask

    initial begin
        int s;
        int k;
        reset    = 1'b1;
        start    = 1'b0;
        bank_sel = 1'b0;
        mode     = 1'b0;
        abort    = 1'b0;
        rd_ready = 1'b1;
        in_valid = '0;
        in_data  = '0;
        ring_idx = '{0, 0};
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_busy", 64'(busy), 64'd0);
        check_eq("rst_shift", 64'(shift), 64'd0);
        check_eq("rst_rd_valid", 64'(rd_valid), 64'd0);
        check_eq("rst_rd_last", 64'(rd_last), 64'd0);
        check_eq("rst_done", 64'(done), 64'd0);
        check_eq("rst_err_miss", 64'(dut.err_miss_q), 64'd0);
        check_eq("rst_last_bank", 64'(dut.last_bank_q), 64'd0);
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Ordering readout of bank 1 at full rate.
        issue_start(1'b1, 1'b0, s);
        check_eq("t1_busy_high", 64'(busy), 64'd1);
        wait_done("t1");
        check_eq("t1_shift1", 64'(shift_seen[1]), 64'd64);
        check_eq("t1_shift0", 64'(shift_seen[0]), 64'd0);
        check_words("t1", 1, 64);
        if (got_c.size() == 64) begin
            check_eq("t1_latency", 64'(got_c[0] - (s + 1)), 64'd2);
            check_eq("t1_rate", 64'(got_c[63] - got_c[0]), 64'd63);
        end
        check_eq("t1_busy_low", 64'(busy), 64'd0);
        check_eq("t1_last_bank", 64'(dut.last_bank_q), 64'd1);
        check_eq("t1_err_miss", 64'(dut.err_miss_q), 64'd0);

        // Distance readout of bank 0 with the consumer stalled.
        rd_ready = 1'b0;
        issue_start(1'b0, 1'b1, s);
        repeat (20) @(posedge clk);
        #1;
        check_eq("t2_stall_shifts", 64'(shift_seen[0]), 64'd4);
        check_eq("t2_stall_count", 64'(dut.u_fifo.count), 64'd4);
        check_eq("t2_stall_valid", 64'(rd_valid), 64'd1);
        rd_ready = 1'b1;
        wait_done("t2");
        check_eq("t2_shifts", 64'(shift_seen[0]), 64'd16);
        check_words("t2", 0, 16);
        check_eq("t2_last_bank", 64'(dut.last_bank_q), 64'd0);

        // Fill, then alternate ready every cycle against a full FIFO.
        rd_ready = 1'b0;
        issue_start(1'b1, 1'b0, s);
        repeat (8) @(posedge clk);
        #1;
        toggle = 1'b1;
        wait_done("t3");
        toggle = 1'b0;
        #3;
        rd_ready = 1'b1;
        check_eq("t3_peak_occ", 64'(max_occ), 64'd4);
        check_words("t3", 1, 64);

        // Abort after ten words, then a complete readout.
        @(posedge clk); #1;
        issue_start(1'b1, 1'b0, s);
        k = 0;
        while (got_d.size() < 10 && k < 500) begin
            @(posedge clk); #1;
            k++;
        end
        check_eq("t4_words_before_abort", 64'(got_d.size() >= 10), 64'd1);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check_eq("t4_rd_valid", 64'(rd_valid), 64'd0);
        check_eq("t4_done", 64'(done), 64'd1);
        check_eq("t4_busy", 64'(busy), 64'd0);
        @(posedge clk); #1;
        check_eq("t4_done_once", 64'(done), 64'd0);
        issue_start(1'b1, 1'b0, s);
        wait_done("t4b");
        check_words("t4b", 1, 64);

        // Reset in the middle of a stalled readout.
        rd_ready = 1'b0;
        issue_start(1'b0, 1'b0, s);
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check_eq("t5_busy", 64'(busy), 64'd0);
        check_eq("t5_shift", 64'(shift), 64'd0);
        check_eq("t5_rd_valid", 64'(rd_valid), 64'd0);
        check_eq("t5_rd_last", 64'(rd_last), 64'd0);
        check_eq("t5_rd_data", rd_data, 64'd0);
        check_eq("t5_done", 64'(done), 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        rd_ready = 1'b1;
        @(posedge clk); #1;
        check_eq("t5_post_shift", 64'(shift), 64'd0);
        check_eq("t5_post_valid", 64'(rd_valid), 64'd0);
        check_eq("t5_post_busy", 64'(busy), 64'd0);

        // Missing in_valid on the fifth shift.
        miss_idx = 4;
        issue_start(1'b0, 1'b1, s);
        wait_done("t6");
        miss_idx = -1;
        check_eq("t6_err_miss", 64'(dut.err_miss_q), 64'd1);
        check_words("t6", 0, 16);
        issue_start(1'b1, 1'b1, s);
        check_eq("t6b_err_cleared", 64'(dut.err_miss_q), 64'd0);
        wait_done("t6b");
        check_words("t6b", 1, 16);
        check_eq("t6b_last_bank", 64'(dut.last_bank_q), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
